// File: rtl/state_test.sv
// ---------------------------------------------------------------------------
// state_test
//
// Autonomous turn sequencer for the two-player tic-tac-toe game. It walks a
// fixed IDLE / P1 / P2 / DRAW sequence, staying a programmable number of
// prescaled ticks in each state, and exposes the current state code and a
// per-state tick timer for display and debug. There are no data inputs.
//
// Optional build macro: STATE_TEST_COUNTDOWN_EN
//   undefined : Timer counts elapsed ticks up from 0 in each state
//   defined   : Timer counts remaining ticks down to 0 in each state
//   The state sequence and its timing are the same in both builds.
//
// Ports:
//   clock  in   1  system clock, rising edge
//   reset  in   1  asynchronous, active-low reset
//   state  out  4  current state code (0..7 legal), registered
//   Timer  out  8  tick timer for the current state, registered
// ---------------------------------------------------------------------------
module state_test #(
    parameter int unsigned PRESCALE    = 4,
    parameter int unsigned DWELL_IDLE  = 4,
    parameter int unsigned DWELL_WAIT  = 8,
    parameter int unsigned DWELL_PLACE = 2,
    parameter int unsigned DWELL_CHECK = 2,
    parameter int unsigned DWELL_DRAW  = 16
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] state,
    output logic [7:0] Timer
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        P1_WAIT  = 4'd1,
        P1_PLACE = 4'd2,
        P1_CHECK = 4'd3,
        P2_WAIT  = 4'd4,
        P2_PLACE = 4'd5,
        P2_CHECK = 4'd6,
        DRAW     = 4'd7
    } state_t;

    // Dwell values minus one; a dwell of 256 still fits the 8-bit timer.
    localparam logic [15:0] PRESCALE_M1 = 16'(PRESCALE - 1);
    localparam logic [7:0]  IDLE_M1     = 8'(DWELL_IDLE - 1);
    localparam logic [7:0]  WAIT_M1     = 8'(DWELL_WAIT - 1);
    localparam logic [7:0]  PLACE_M1    = 8'(DWELL_PLACE - 1);
    localparam logic [7:0]  CHECK_M1    = 8'(DWELL_CHECK - 1);
    localparam logic [7:0]  DRAW_M1     = 8'(DWELL_DRAW - 1);
    localparam logic [3:0]  MAX_MOVES   = 4'd9;

    // Value the timer takes whenever IDLE is entered (reset or recovery).
`ifdef STATE_TEST_COUNTDOWN_EN
    localparam logic [7:0] TIMER_IDLE_INIT = IDLE_M1;
`else
    localparam logic [7:0] TIMER_IDLE_INIT = 8'd0;
`endif

    logic [15:0] prescale_cnt;
    logic [3:0]  move_cnt;
    logic        tick;
    logic        expire;
    logic [7:0]  dwell_m1;
    logic [3:0]  next_state;
    logic [7:0]  next_dwell_m1;

    // Last timer value of a state; illegal codes map to 0 but never use it.
    function automatic logic [7:0] dwell_m1_of(input logic [3:0] s);
        logic [7:0] d;
        d = 8'd0;
        case (s)
            IDLE:                         d = IDLE_M1;
            P1_WAIT, P2_WAIT:             d = WAIT_M1;
            P1_PLACE, P2_PLACE:           d = PLACE_M1;
            P1_CHECK, P2_CHECK:           d = CHECK_M1;
            DRAW:                         d = DRAW_M1;
            default:                      d = 8'd0;
        endcase
        return d;
    endfunction

    assign tick     = (prescale_cnt == PRESCALE_M1);
    assign dwell_m1 = dwell_m1_of(state);

    // Dwell expiry: the timer has reached the far end of its range.
`ifdef STATE_TEST_COUNTDOWN_EN
    assign expire = (Timer == 8'd0);
`else
    assign expire = (Timer == dwell_m1);
`endif

    // Successor state on dwell expiry. The move counter has already been
    // bumped on the PLACE exit, so the CHECK states see the updated count.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:     next_state = P1_WAIT;
            P1_WAIT:  next_state = P1_PLACE;
            P1_PLACE: next_state = P1_CHECK;
            P1_CHECK: next_state = (move_cnt == MAX_MOVES) ? DRAW : P2_WAIT;
            P2_WAIT:  next_state = P2_PLACE;
            P2_PLACE: next_state = P2_CHECK;
            P2_CHECK: next_state = (move_cnt == MAX_MOVES) ? DRAW : P1_WAIT;
            DRAW:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign next_dwell_m1 = dwell_m1_of(next_state);

    // Prescaler, sequencer and move counter. Illegal codes recover to IDLE
    // on the very next edge regardless of the tick; in the countdown build
    // that recovery loads the IDLE dwell like any other entry into IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale_cnt <= 16'd0;
            state        <= IDLE;
            Timer        <= TIMER_IDLE_INIT;
            move_cnt     <= 4'd0;
        end else begin
            prescale_cnt <= tick ? 16'd0 : prescale_cnt + 16'd1;

            if (state > DRAW) begin
                state    <= IDLE;
                Timer    <= TIMER_IDLE_INIT;
                move_cnt <= 4'd0;
            end else begin
                if (state == IDLE) begin
                    move_cnt <= 4'd0;
                end

                if (tick) begin
                    if (expire) begin
                        state <= next_state;
`ifdef STATE_TEST_COUNTDOWN_EN
                        Timer <= next_dwell_m1;
`else
                        Timer <= 8'd0;
`endif
                        if ((state == P1_PLACE || state == P2_PLACE) &&
                            move_cnt != MAX_MOVES) begin
                            move_cnt <= move_cnt + 4'd1;
                        end
                    end else begin
`ifdef STATE_TEST_COUNTDOWN_EN
                        Timer <= Timer - 8'd1;
`else
                        Timer <= Timer + 8'd1;
`endif
                    end
                end
            end
        end
    end

`ifndef STATE_TEST_COUNTDOWN_EN
    // Only the countdown build needs the successor's dwell.
    logic unused_next_dwell;
    assign unused_next_dwell = ^next_dwell_m1;
`endif

endmodule

// File: tb/tb_state_test.sv
// ---------------------------------------------------------------------------
// tb_state_test
//
// Scoreboard bench for state_test. A reference process predicts the outputs
// after every rising edge from the number of edges since reset release,
// using a table of (state, dwell) segments for one whole game; predictions
// are queued and a separate monitor pops and compares them on each falling
// edge, or immediately after an asynchronous reset assertion.
// ---------------------------------------------------------------------------
module tb_state_test;

    localparam int PRESCALE    = 4;
    localparam int DWELL_IDLE  = 4;
    localparam int DWELL_WAIT  = 8;
    localparam int DWELL_PLACE = 2;
    localparam int DWELL_CHECK = 2;
    localparam int DWELL_DRAW  = 16;

`ifdef STATE_TEST_COUNTDOWN_EN
    localparam bit COUNTDOWN = 1'b1;
`else
    localparam bit COUNTDOWN = 1'b0;
`endif

    typedef struct {
        logic [3:0] st;
        logic [7:0] tm;
        int         edge_n;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] state;
    logic [7:0] Timer;

    exp_t exp_q[$];
    int   seg_st[$];
    int   seg_len[$];
    int   game_len;
    int   edges;
    int   checks;
    int   errors;
    bit   illegal_pending;
    event mid_ev;

    state_test #(
        .PRESCALE   (PRESCALE),
        .DWELL_IDLE (DWELL_IDLE),
        .DWELL_WAIT (DWELL_WAIT),
        .DWELL_PLACE(DWELL_PLACE),
        .DWELL_CHECK(DWELL_CHECK),
        .DWELL_DRAW (DWELL_DRAW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .state(state),
        .Timer(Timer)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One game: IDLE, five P1 rounds interleaved with four P2 rounds (nine
    // moves fill the board), then DRAW.
    function automatic void build_game();
        seg_st.push_back(0); seg_len.push_back(DWELL_IDLE);
        for (int r = 1; r <= 5; r++) begin
            seg_st.push_back(1); seg_len.push_back(DWELL_WAIT);
            seg_st.push_back(2); seg_len.push_back(DWELL_PLACE);
            seg_st.push_back(3); seg_len.push_back(DWELL_CHECK);
            if (r < 5) begin
                seg_st.push_back(4); seg_len.push_back(DWELL_WAIT);
                seg_st.push_back(5); seg_len.push_back(DWELL_PLACE);
                seg_st.push_back(6); seg_len.push_back(DWELL_CHECK);
            end
        end
        seg_st.push_back(7); seg_len.push_back(DWELL_DRAW);
        game_len = 0;
        foreach (seg_len[i]) game_len += seg_len[i];
    endfunction

    function automatic exp_t idle_expect(int n);
        exp_t e;
        e.st     = 4'd0;
        e.tm     = COUNTDOWN ? 8'(DWELL_IDLE - 1) : 8'd0;
        e.edge_n = n;
        return e;
    endfunction

    // Expected outputs after edge n counted from reset release.
    function automatic exp_t model(int n);
        exp_t e;
        int   g;
        g        = (n / PRESCALE) % game_len;
        e.st     = 4'd0;
        e.tm     = 8'd0;
        e.edge_n = n;
        foreach (seg_len[i]) begin
            if (g >= 0 && g < seg_len[i]) begin
                e.st = 4'(seg_st[i]);
                e.tm = COUNTDOWN ? 8'(seg_len[i] - 1 - g) : 8'(g);
            end
            g -= seg_len[i];
        end
        return e;
    endfunction

    // Reference process: one prediction per rising edge.
    initial begin
        edges = 0;
        forever begin
            @(posedge clock);
            #1;
            if (illegal_pending) begin
                illegal_pending = 1'b0;
                exp_q.push_back(idle_expect(-1));
            end else if (!reset) begin
                edges = 0;
                exp_q.push_back(idle_expect(0));
            end else begin
                edges++;
                exp_q.push_back(model(edges));
            end
        end
    end

    // Monitor: compares the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or mid_ev);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    task automatic check_output(input exp_t e);
        checks++;
        if (state !== e.st || Timer !== e.tm) begin
            errors++;
            $display("[TB] FAIL edge%0d: state=%0d Timer=%0d, expected state=%0d Timer=%0d",
                     e.edge_n, state, Timer, e.st, e.tm);
        end
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called just after a falling edge; the DUT must clear before any edge.
    task automatic assert_reset_async();
        #1 reset = 1'b0;
        #1 exp_q.push_back(idle_expect(-2));
        ->mid_ev;
    endtask

    task automatic release_reset();
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    // Called just after a falling edge; plants code 12 in the state register.
    task automatic force_illegal();
        #1;
        illegal_pending = 1'b1;
        force dut.state = 4'd12;
        #1 release dut.state;
        @(negedge clock);
    endtask

    task automatic apply_stimulus();
        reset = 1'b0;
        run_edges(5000);

        release_reset();
        run_edges(1100);

        // Reset mid-P2_WAIT of the first round, then a full game to DRAW.
        assert_reset_async();
        run_edges(3);
        release_reset();
        run_edges(79);
        assert_reset_async();
        run_edges(2);
        release_reset();
        run_edges(460);

        force_illegal();
        assert_reset_async();
        run_edges(2);
        release_reset();

        for (int i = 0; i < 8; i++) begin
            run_edges($urandom_range(1, 700));
            if ($urandom_range(0, 3) == 0) force_illegal();
            assert_reset_async();
            run_edges($urandom_range(1, 10));
            release_reset();
        end
        run_edges(200);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        illegal_pending = 1'b0;
        reset           = 1'b0;
        build_game();
        apply_stimulus();
        run_edges(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
